fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of the async FIFO between several requesters in the write clock domain. It grants one requester at a time for a bounded burst and drives the FIFO `w_inc`/`w_data`. It never writes while `w_full` is high and acknowledges each accepted word back to its owner. It sits directly in front of the FIFO write port, clocked by the FIFO write clock.

## Interface
- `num_req`, default 4: number of requesters, 2..8.
- `data_width`, default 8: word width; must match the FIFO.
- `max_burst`, default 4: maximum words per grant, 1..(2^`cnt_width`-1).
- `cnt_width`, default 3: width of the beat counter.

Ports:
- `clk`  in  1  write clock, same as FIFO `w_clk`.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  `num_req`  per-requester write request; level, held until `ack` or withdrawn.
- `req_data`  in  `num_req*data_width`  packed words; slice i belongs to requester i.
- `w_full`  in  1  FIFO full flag, write domain.
- `gnt`  out  `num_req`  one-hot registered grant; all-zero when idle.
- `ack`  out  `num_req`  one-hot; high in the cycle the owner's word is written.
- `w_inc`  out  1  FIFO write enable.
- `w_data`  out  `data_width`  FIFO write data.
- `busy`  out  1  high while in BURST.

## Operation
FSM states and transitions:
- IDLE → BURST when any `req` is high.
  - Winner is the first requester at or after `last_owner+1`, modulo `num_req`.
  - On entry, register `owner`, set `gnt[owner]`, clear `beat_cnt`, set `last_owner <= owner`.
- BURST: `xfer = req[owner] & ~w_full`.
  - `w_inc = xfer`, `ack[owner] = xfer`, `w_data = req_data[owner slice]`.
  - On `xfer`, `beat_cnt` increments.
- BURST → IDLE (`gnt` cleared next cycle) in either case:
  - `xfer` with `beat_cnt == max_burst-1`, i.e. the last beat is written this cycle.
  - `req[owner]` low, with no transfer this cycle.

Rules and boundary conditions:
- A `w_full` stall does not count a beat and does not release the grant. There is no timeout.
- `w_full` high and `req[owner]` dropping in the same cycle: release.
- Requesters other than the owner are ignored during BURST. Their `req` may change freely.
- The requester must hold `req_data` stable while `req` is high and `ack` is low.
- Wrap-around: the search index wraps from `num_req-1` to 0. A lone requester is regranted after one IDLE cycle.
- `w_data` is all-zero when `w_inc` is low.
- `beat_cnt` is never compared beyond `max_burst-1`. Width `cnt_width` is sufficient by parameter rule.

Reset (asynchronous, any state, including mid-burst):
- State IDLE; `gnt`, `ack`, `w_inc`, `busy` = 0; `w_data` = 0; `beat_cnt` = 0.
- `last_owner` = `num_req-1`, so the first arbitration favours requester 0.
- An in-flight burst is abandoned. Unwritten words remain owned by their requesters.

## Timing
- `req` seen high in IDLE at cycle 0 → `gnt`/`busy` high at cycle 1; first `w_inc` possible at cycle 1.
- Full burst with no stalls: `max_burst` consecutive `w_inc` cycles, then exactly one IDLE cycle before the next grant.
  - Throughput under saturation: `max_burst`/(`max_burst`+1) words per cycle.
- `w_full` → `w_inc`/`ack` is a combinational path, same cycle. `req[owner]` → `w_inc` is also combinational.
- `gnt`, `busy`, state, `owner`, `beat_cnt` and `last_owner` are registered.

## Configuration
- `FIFO_ARB_HIPRI_EN` defined:
  - In IDLE, requester 0 wins whenever `req[0]` is high, regardless of `last_owner`.
  - Other requesters fall back to round-robin. Burst limits still apply to requester 0.
- Not defined: pure round-robin; requester 0 has no precedence.

## Test plan
1. `num_req`=4, `max_burst`=4, `req`=4'b1111 held, `w_full`=0.
   - Grants 0,1,2,3,0 in that order; each gives 4 `w_inc`, then 1 idle cycle; 16 words in 20 cycles.
   - Every `w_data` equals the owner's slice.
2. Requester 1 owns the grant; `w_full` high for 3 cycles after its 2nd word.
   - `w_inc`=0 and `ack`=0 during the stall; `gnt`=4'b0010 held.
   - Exactly 4 words total, then release.
3. Requester 2 drops `req` after 2 acks.
   - Release the next cycle with no write; the next grant goes to requester 3 if it is requesting.
4. Assert `rst` mid-burst (owner 3, `beat_cnt`=2).
   - `gnt`=0, `w_inc`=0, `busy`=0 immediately.
   - After deassert with `req`=4'b1111, the first grant is requester 0.
5. `FIFO_ARB_HIPRI_EN` defined, `req`=4'b1001 held: every grant goes to requester 0.
   - Undefined: grants alternate 0,3,0,3.
6. Single requester `req`=4'b0100 with `max_burst`=1, held for 6 cycles.
   - `w_inc` pattern 1,0,1,0,1,0; `gnt`=4'b0100 in alternate cycles.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one requester at a time for a bounded burst onto the FIFO write port.
// Optional macro FIFO_ARB_HIPRI_EN gives requester 0 absolute precedence at arbitration time.
module fifo_wr_arbiter #(
    parameter int num_req    = 4,
    parameter int data_width = 8,
    parameter int max_burst  = 4,
    parameter int cnt_width  = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [num_req-1:0]              req,
    input  logic [num_req*data_width-1:0]   req_data,
    input  logic                            w_full,
    output logic [num_req-1:0]              gnt,
    output logic [num_req-1:0]              ack,
    output logic                            w_inc,
    output logic [data_width-1:0]           w_data,
    output logic                            busy
);

    localparam int                   ow        = (num_req > 1) ? $clog2(num_req) : 1;
    localparam logic [cnt_width-1:0] last_beat = cnt_width'(max_burst - 1);
    localparam logic [ow-1:0]        last_idx  = ow'(num_req - 1);
    localparam logic [num_req-1:0]   one_lsb   = {{(num_req-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state_r;
    logic [ow-1:0]          owner_r;
    logic [ow-1:0]          last_owner_r;
    logic [cnt_width-1:0]   beat_cnt_r;
    logic [num_req-1:0]     gnt_r;
    logic                   busy_r;

    logic [ow-1:0]          winner_s;
    logic [ow-1:0]          idx_s;
    logic                   found_s;
    logic                   xfer_s;

    // Round-robin search starting just after the previous owner.
    always_comb begin
        winner_s = last_idx;
        idx_s    = '0;
        found_s  = 1'b0;
        for (int i = 1; i <= num_req; i++) begin
            idx_s = ow'((int'(last_owner_r) + i) % num_req);
            if (!found_s && req[idx_s]) begin
                winner_s = idx_s;
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
`ifdef FIFO_ARB_HIPRI_EN
        if (req[0]) begin
            winner_s = '0;
        end else begin
            winner_s = winner_s;
        end
`endif
    end

    assign xfer_s = busy_r & req[owner_r] & ~w_full;

    // Write-side outputs follow w_full and req[owner] in the same cycle.
    always_comb begin
        w_inc  = xfer_s;
        ack    = '0;
        w_data = '0;
        if (xfer_s) begin
            ack    = one_lsb << owner_r;
            w_data = req_data[int'(owner_r)*data_width +: data_width];
        end else begin
            ack    = '0;
            w_data = '0;
        end
    end

    assign gnt  = gnt_r;
    assign busy = busy_r;

    // Arbitration FSM; stalls hold the grant, a dropped request releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= '0;
            last_owner_r <= last_idx;
            beat_cnt_r   <= '0;
            gnt_r        <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|req) begin
                        state_r      <= BURST;
                        owner_r      <= winner_s;
                        last_owner_r <= winner_s;
                        beat_cnt_r   <= '0;
                        gnt_r        <= one_lsb << winner_s;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                BURST: begin
                    if (xfer_s) begin
                        if (beat_cnt_r == last_beat) begin
                            state_r <= IDLE;
                            gnt_r   <= '0;
                            busy_r  <= 1'b0;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + cnt_width'(1);
                        end
                    end else if (!req[owner_r]) begin
                        state_r <= IDLE;
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= BURST;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic              w_full = 1'b0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     ack;
    logic              w_inc;
    logic [DW-1:0]     w_data;
    logic              busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .num_req(NR), .data_width(DW), .max_burst(MB), .cnt_width(CW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .w_full(w_full),
        .gnt(gnt), .ack(ack), .w_inc(w_inc), .w_data(w_data), .busy(busy)
    );

    typedef struct packed {
        logic [NR-1:0] ack;
        logic [DW-1:0] data;
    } wr_t;

    int            tests = 0;
    int            fails = 0;
    wr_t           wq[$];
    logic [NR-1:0] cq[$];

    int            m_owner = -1;
    int            m_words = 0;
    int            m_last  = NR - 1;
    logic [NR-1:0] m_ack   = '0;

    bit hold_all = 1'b0;
    int full_pct = 0;
    int drop_pct = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int last);
`ifdef FIFO_ARB_HIPRI_EN
        if (r[0]) return 0;
`endif
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // Reference model: decides this cycle's grant and write from the arbitration rules.
    always @(negedge clk) begin
        logic [NR-1:0] eg;
        wr_t           e;
        m_ack = '0;
        if (rst) begin
            m_owner = -1;
            m_words = 0;
            m_last  = NR - 1;
        end else begin
            eg = '0;
            if (m_owner >= 0) eg[m_owner] = 1'b1;
            cq.push_back(eg);
            if (m_owner >= 0) begin
                if (req[m_owner] && !w_full) begin
                    e.ack  = eg;
                    e.data = req_data[m_owner*DW +: DW];
                    wq.push_back(e);
                    m_ack[m_owner] = 1'b1;
                    m_words++;
                    if (m_words == MB) m_owner = -1;
                end else if (!req[m_owner]) begin
                    m_owner = -1;
                end
            end else if (|req) begin
                m_owner = pick(req, m_last);
                m_last  = m_owner;
                m_words = 0;
            end
        end
    end

    // Monitor: compares DUT outputs against the queued expectations.
    always begin
        logic [NR-1:0] eg;
        wr_t           e;
        @(negedge clk);
        #1;
        if (rst) begin
            check("rst_outputs", {gnt, ack, busy, w_inc, w_data}, '0);
        end else begin
            if (cq.size() == 0) begin
                tests++; fails++;
                $display("FAIL cycle_queue: got empty expected entry at %0t", $time);
            end else begin
                eg = cq.pop_front();
                check("gnt", gnt, eg);
                check("busy", busy, |eg);
            end
            if (w_inc) begin
                if (wq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got w_inc=1 data=%0h expected no write at %0t", w_data, $time);
                end else begin
                    e = wq.pop_front();
                    check("ack", ack, e.ack);
                    check("w_data", w_data, e.data);
                end
            end else begin
                check("idle_ack_data", {ack, w_data}, '0);
            end
            check("missed_write", wq.size(), 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hold_all) begin
                if (m_ack[i] || !req[i]) req_data[i*DW +: DW] = DW'($urandom);
                req[i] = 1'b1;
            end else if (req[i] && m_ack[i]) begin
                req_data[i*DW +: DW] = DW'($urandom);
                req[i] = ($urandom_range(99) < 70);
            end else if (req[i]) begin
                if ($urandom_range(99) < drop_pct) req[i] = 1'b0;
            end else if ($urandom_range(99) < 30) begin
                req_data[i*DW +: DW] = DW'($urandom);
                req[i] = 1'b1;
            end
        end
        w_full = ($urandom_range(99) < full_pct);
    endtask

    initial begin
        bit hit;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {gnt, ack, busy, w_inc, w_data}, '0);
        rst = 1'b0;

        // Saturation: round-robin 0,1,2,3 with full bursts.
        hold_all = 1'b1; full_pct = 0;
        repeat (45) step();

        // Reset in the middle of requester 3's burst after two words.
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            step();
            if (m_owner == 3 && m_words == 2) hit = 1'b1;
        end
        if (!hit) begin
            tests++; fails++;
            $display("FAIL reset_window: got no owner3/beat2 window expected one within 200 cycles");
        end else begin
            #1;
            rst = 1'b1;
            #1;
            check("async_reset", {gnt, busy, w_inc}, '0);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        repeat (30) step();

        hold_all = 1'b0; full_pct = 30; drop_pct = 5;
        repeat (1500) step();
        full_pct = 60; drop_pct = 0;
        repeat (500) step();
        hold_all = 1'b1; full_pct = 20;
        repeat (300) step();

        hold_all = 1'b0; full_pct = 0;
        @(posedge clk); #1; req = '0;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        check("final_queue", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
